// File: rtl/neuron_serial.sv
// Serial multiply-accumulate neuron: bias + sum(input[k]*weight[k]), ReLU, fixed-point rescale.
// Define NEURON_SATURATE_EN to clamp oversized results to all-ones instead of wrapping.
module neuron_serial #(
  parameter int unsigned N_INPUTS  = 9,
  parameter int unsigned IN_W      = 9,
  parameter int unsigned W_W       = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned OUT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       start_,
  input  logic [N_INPUTS*IN_W-1:0]   inputs,
  input  logic [N_INPUTS*W_W-1:0]    weights,
  input  logic signed [W_W-1:0]      bias,
  output logic [OUT_W-1:0]           out,
  output logic                       end_,
  output logic                       busy
);

  localparam int unsigned ACC_W  = IN_W + W_W + $clog2(N_INPUTS) + 1;
  localparam int unsigned IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned PROD_W = IN_W + W_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, DONE} state_t;

  state_t                  state;
  logic [IN_W-1:0]         in_r [N_INPUTS];
  logic signed [W_W-1:0]   w_r  [N_INPUTS];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic signed [PROD_W-1:0] prod_c;
  logic [OUT_W-1:0]        act_c;

  // Input is zero-extended so it multiplies as a non-negative signed value.
  always_comb begin
    prod_c = PROD_W'($signed({1'b0, in_r[idx]})) * PROD_W'(w_r[idx]);
  end

  // ReLU followed by the fixed-point shift; only positive values reach the shift.
  always_comb begin
    act_c = '0;
    if (!acc[ACC_W-1] && (|acc)) begin
`ifdef NEURON_SATURATE_EN
      if (|acc[ACC_W-2:FRAC_BITS+OUT_W]) begin
        act_c = '1;
      end else begin
        act_c = acc[FRAC_BITS +: OUT_W];
      end
`else
      act_c = acc[FRAC_BITS +: OUT_W];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      out   <= '0;
      end_  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      end_ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_) begin
            for (int k = 0; k < N_INPUTS; k++) begin
              in_r[k] <= inputs[k*IN_W +: IN_W];
              w_r[k]  <= weights[k*W_W +: W_W];
            end
            acc   <= ACC_W'(bias);
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(prod_c);
          if (idx == IDX_W'(N_INPUTS - 1)) begin
            state <= ACT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ACT: begin
          out   <= act_c;
          state <= DONE;
        end
        DONE: begin
          end_  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_serial.sv
// Scoreboard bench for neuron_serial: directed vectors queue expected outputs,
// a negedge monitor checks each end_ pulse against the queue.
module tb_neuron_serial;

  localparam int unsigned N     = 9;
  localparam int unsigned IN_W  = 9;
  localparam int unsigned W_W   = 32;
  localparam int unsigned OUT_W = 8;
`ifdef NEURON_SATURATE_EN
  localparam logic [OUT_W-1:0] BIG_EXP = 8'd255;
`else
  localparam logic [OUT_W-1:0] BIG_EXP = 8'd132;
`endif

  logic                  clk = 1'b0;
  logic                  reset_ = 1'b0;
  logic                  start_ = 1'b0;
  logic [N*IN_W-1:0]     inputs = '0;
  logic [N*W_W-1:0]      weights = '0;
  logic signed [W_W-1:0] bias = '0;
  logic [OUT_W-1:0]      out;
  logic                  end_;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_v;
  int bc;
  int ends_seen;

  neuron_serial dut (
    .clk(clk), .reset_(reset_), .start_(start_), .inputs(inputs),
    .weights(weights), .bias(bias), .out(out), .end_(end_), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_ && end_) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_end: end_=1 out=%0d with nothing expected", out);
      end else begin
        exp_v = exp_q.pop_front();
        if (out !== exp_v) begin
          errors++;
          $display("FAIL result: out=%0d required=%0d", out, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // mode 0: inputs 1..N, mode 1: all inputs 1
  task automatic set_ops(input int mode, input int wv, input int bv);
    for (int k = 0; k < N; k++) begin
      inputs[k*IN_W +: IN_W] = (mode == 0) ? IN_W'(k + 1) : IN_W'(1);
      weights[k*W_W +: W_W]  = W_W'(wv);
    end
    bias = W_W'(bv);
  endtask

  task automatic start_once();
    @(negedge clk) start_ = 1'b1;
    @(posedge clk);
    #1 start_ = 1'b0;
  endtask

  // Counts edges until end_ appears; busy_cnt counts busy samples on the way.
  task automatic wait_end(input string name, input int exp_lat, output int busy_cnt);
    int n;
    bit seen;
    n = 0; seen = 1'b0; busy_cnt = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_cnt++;
      if (end_) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no end_ within %0d cycles required latency %0d", name, n, exp_lat);
    end else begin
      check({name, "_latency"}, n, exp_lat);
    end
  endtask

  task automatic idle_no_end(input string name, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (end_) cnt++;
    end
    check(name, cnt, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_end", end_, 0);
    check("reset_busy", busy, 0);
    @(negedge clk) reset_ = 1'b1;

    // Basic evaluation: 45 * 256 >> 8 = 45
    set_ops(0, 256, 0);
    exp_q.push_back(8'd45);
    start_once();
    wait_end("t_basic", 11, bc);
    check("t_basic_busy_cycles", bc, 10);
    check("t_basic_busy_at_end", busy, 0);
    @(posedge clk);
    #1;
    check("t_basic_end_one_cycle", end_, 0);
    check("t_basic_out_held", out, 45);

    // Negative sum clipped by ReLU
    set_ops(0, -256, 0);
    exp_q.push_back(8'd0);
    start_once();
    wait_end("t_relu", 11, bc);

    // 9 * 25600 >> 8 = 900: saturates or wraps
    set_ops(1, 25600, 0);
    exp_q.push_back(BIG_EXP);
    start_once();
    wait_end("t_big", 11, bc);

    // Bias -2560 -> 35; a second start_ at cycle 3 must be ignored
    set_ops(0, 256, -2560);
    exp_q.push_back(8'd35);
    start_once();
    repeat (2) @(posedge clk);
    @(negedge clk) start_ = 1'b1;
    @(posedge clk);
    #1 start_ = 1'b0;
    wait_end("t_retrigger", 8, bc);
    idle_no_end("t_retrigger_single_end", 15);

    // Held start_: back-to-back runs; operand change after latching hits only the second
    set_ops(0, 256, 0);
    exp_q.push_back(8'd45);
    exp_q.push_back(8'd35);
    @(negedge clk) start_ = 1'b1;
    @(posedge clk);
    #1;
    set_ops(0, 256, -2560);
    wait_end("t_b2b_first", 11, bc);
    wait_end("t_b2b_second", 12, bc);
    start_ = 1'b0;
    idle_no_end("t_b2b_stop", 15);

    // Reset in the middle of accumulation
    set_ops(0, 256, 0);
    start_once();
    repeat (4) @(posedge clk);
    @(negedge clk) reset_ = 1'b0;
    @(posedge clk);
    #1;
    check("t_midreset_busy", busy, 0);
    check("t_midreset_out", out, 0);
    check("t_midreset_end", end_, 0);
    @(negedge clk) reset_ = 1'b1;
    idle_no_end("t_midreset_no_end", 15);
    set_ops(0, 256, -2560);
    exp_q.push_back(8'd35);
    start_once();
    wait_end("t_after_reset", 11, bc);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_serial.md
NEURON_SERIAL -- requirements
Module: neuron_serial

Interface
REQ-001 SHALL have parameter N_INPUTS, default 9, meaning number of synaptic inputs (>=1).
REQ-002 SHALL have parameter IN_W, default 9, meaning unsigned width of each input.
REQ-003 SHALL have parameter W_W, default 32, meaning two's-complement width of each weight and of the bias.
REQ-004 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of the weight fixed-point format.
REQ-005 SHALL have parameter OUT_W, default 8, meaning unsigned output width.
REQ-006 SHALL derive localparam ACC_W = IN_W + W_W + $clog2(N_INPUTS) + 1 for the signed accumulator.
REQ-007 SHALL use one clock with synchronous, active-low reset, ports clk and reset_.
REQ-008 SHALL have port clk, input, 1 bit, meaning rising-edge clock.
REQ-009 SHALL have port reset_, input, 1 bit, meaning synchronous active-low reset.
REQ-010 SHALL have port start_, input, 1 bit, meaning request to begin one evaluation.
REQ-011 SHALL have port inputs, input, N_INPUTS*IN_W bits, meaning packed unsigned inputs, input k at bits [k*IN_W +: IN_W].
REQ-012 SHALL have port weights, input, N_INPUTS*W_W bits, meaning packed signed weights, weight k at bits [k*W_W +: W_W].
REQ-013 SHALL have port bias, input, W_W bits, meaning signed bias in the product scale (FRAC_BITS fractional).
REQ-014 SHALL have port out, output, OUT_W bits, meaning activated result, held until the next completion.
REQ-015 SHALL have port end_, output, 1 bit, meaning one-cycle completion pulse.
REQ-016 SHALL have port busy, output, 1 bit, meaning evaluation in progress.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, ACT, DONE.
REQ-018 In IDLE, start_=1 SHALL latch inputs, weights and bias, load accumulator with sign-extended bias, clear index, and go to ACCUM.
REQ-019 ACCUM SHALL perform one MAC per cycle (acc += signed(input[idx]) * weight[idx], input zero-extended), idx 0..N_INPUTS-1 in order, then go to ACT.
REQ-020 ACT SHALL compute ReLU(acc) >>> FRAC_BITS (truncate toward zero), apply the output rule of REQ-030/031, register into out, and go to DONE.
REQ-021 DONE SHALL assert end_ for exactly one cycle and return to IDLE.
REQ-022 Latency: start_ sampled at edge 0 -> end_ high in the cycle after edge N_INPUTS+2; out valid in the same cycle and held thereafter.
REQ-023 busy SHALL be 1 in ACCUM, ACT and DONE, and 0 in IDLE.
REQ-024 start_ while busy=1 SHALL be ignored, with no queuing.
REQ-025 start_ held high continuously SHALL start a new evaluation in the IDLE cycle following DONE (back-to-back, one idle cycle).
REQ-026 Changes on inputs, weights or bias after the latching edge SHALL NOT affect the current result.
REQ-027 A negative or zero accumulator SHALL produce out=0.
REQ-028 The accumulator SHALL NOT overflow for any legal operand combination, guaranteed by the ACC_W sizing.

Reset
REQ-029 reset_=0 at a rising edge SHALL force IDLE, out=0, end_=0, busy=0, accumulator and index to 0, including mid-evaluation, and SHALL suppress any pending end_.

Configuration
REQ-030 With macro NEURON_SATURATE_EN defined, a shifted result >= 2**OUT_W SHALL produce out = 2**OUT_W-1.
REQ-031 Without NEURON_SATURATE_EN, out SHALL be the low OUT_W bits of the shifted result (wrap).

Verification
REQ-032 Defaults, inputs 1..9, all weights 256, bias 0, start_ pulse -> end_ pulse 11 cycles after start edge, out=45, busy high 10 cycles.
REQ-033 Defaults, inputs 1..9, all weights -256, bias 0 -> out=0 (ReLU).
REQ-034 Defaults, all inputs 1, all weights 25600, bias 0 -> out=255 with NEURON_SATURATE_EN; out=132 without it.
REQ-035 Defaults, inputs 1..9, weights 256, bias -2560 -> out=35; start_ re-pulsed at cycle 3 -> ignored, single end_.
REQ-036 reset_=0 asserted during ACCUM (cycle 5) -> next cycle busy=0, out=0, no end_; a fresh start_ then yields the correct result.
